// File: rtl/lcd_write_controller.sv
// ============================================================================
// Module      : lcd_write_controller
// Description : HD44780 4-bit write-only controller: power-on init, then
//               two-character words or single command bytes over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module lcd_write_controller #(
    parameter int unsigned T_POWERON    = 750000,
    parameter int unsigned T_SETUP      = 2,
    parameter int unsigned T_EHIGH      = 12,
    parameter int unsigned T_NIBBLE_GAP = 50,
    parameter int unsigned T_INIT1      = 205000,
    parameter int unsigned T_INIT2      = 5000,
    parameter int unsigned T_CMD        = 2000,
    parameter int unsigned T_CLEAR      = 82000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        iValid,
    input  logic        iCommand,
    input  logic [15:0] iData,
    output logic        oReady,
    output logic        oInitDone,
    output logic        oLCD_E,
    output logic        oLCD_RS,
    output logic        oLCD_RW,
    output logic [3:0]  oLCD_Data
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned c_MAX_WAIT = max2(max2(max2(T_POWERON, T_INIT1), max2(T_INIT2, T_CLEAR)),
                                              max2(max2(T_CMD, T_SETUP), max2(T_EHIGH, T_NIBBLE_GAP)));
    localparam int c_CNT_W = $clog2(c_MAX_WAIT + 1);

    localparam logic [c_CNT_W-1:0] c_POWERON_LD = c_CNT_W'(T_POWERON - 1);
    localparam logic [c_CNT_W-1:0] c_SETUP_LD   = c_CNT_W'(T_SETUP - 1);
    localparam logic [c_CNT_W-1:0] c_EHIGH_LD   = c_CNT_W'(T_EHIGH - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LD     = c_CNT_W'(T_NIBBLE_GAP - 1);
    localparam logic [c_CNT_W-1:0] c_INIT1_LD   = c_CNT_W'(T_INIT1 - 1);
    localparam logic [c_CNT_W-1:0] c_INIT2_LD   = c_CNT_W'(T_INIT2 - 1);
    localparam logic [c_CNT_W-1:0] c_CMD_LD     = c_CNT_W'(T_CMD - 1);
    localparam logic [c_CNT_W-1:0] c_CLEAR_LD   = c_CNT_W'(T_CLEAR - 1);

    localparam logic [2:0] c_POWER_WAIT = 3'd0;
    localparam logic [2:0] c_NIB_SETUP  = 3'd1;
    localparam logic [2:0] c_NIB_HIGH   = 3'd2;
    localparam logic [2:0] c_NIB_GAP    = 3'd3;
    localparam logic [2:0] c_EXEC_WAIT  = 3'd4;
    localparam logic [2:0] c_IDLE       = 3'd5;
    localparam logic [2:0] c_SKIP       = 3'd6;

    // Init steps 0..3 are single nibbles held in the upper half of the byte
    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: return 8'h30;
            3'd3:             return 8'h20;
            3'd4:             return 8'h28;
            3'd5:             return 8'h06;
            3'd6:             return 8'h0C;
            default:          return 8'h01;
        endcase
    endfunction

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_init_idx;
    logic               r_init_done;
    logic [7:0]         r_byte;
    logic               r_single;
    logic               r_low;
    logic [7:0]         r_pend;
    logic               r_pend_valid;
    logic               r_e;
    logic               r_rs;
    logic [3:0]         r_data;

    logic               w_start;
    logic [7:0]         w_start_byte;
    logic               w_start_rs;
    logic               w_start_single;
    logic [2:0]         w_next_idx;
    logic [c_CNT_W-1:0] w_exec_ld;

    assign w_next_idx = r_init_idx + 3'd1;

    always_comb begin
        w_exec_ld = c_CMD_LD;
        if (r_single) begin
            if (r_init_idx == 3'd0)
                w_exec_ld = c_INIT1_LD;
            else if (r_init_idx == 3'd1)
                w_exec_ld = c_INIT2_LD;
        end else if (!r_rs && (r_byte == 8'h01 || r_byte == 8'h02)) begin
            w_exec_ld = c_CLEAR_LD;
        end
    end

    // Every byte/nibble launch funnels through one start request
    always_comb begin
        w_start        = 1'b0;
        w_start_byte   = r_pend;
        w_start_rs     = 1'b1;
        w_start_single = 1'b0;
        case (r_state)
            c_POWER_WAIT: begin
                if (r_cnt == '0) begin
                    w_start        = 1'b1;
                    w_start_byte   = init_byte(3'd0);
                    w_start_rs     = 1'b0;
                    w_start_single = 1'b1;
                end
            end
            c_EXEC_WAIT: begin
                if (r_cnt == '0) begin
                    if (!r_init_done) begin
                        if (r_init_idx != 3'd7) begin
                            w_start        = 1'b1;
                            w_start_byte   = init_byte(w_next_idx);
                            w_start_rs     = 1'b0;
                            w_start_single = ~w_next_idx[2];
                        end
                    end else if (r_pend_valid) begin
                        w_start = 1'b1;
                    end
                end
            end
            c_IDLE: begin
                if (iValid) begin
                    if (iCommand) begin
                        w_start      = 1'b1;
                        w_start_byte = iData[7:0];
                        w_start_rs   = 1'b0;
                    end else if (iData[15:8] != 8'h00) begin
                        w_start      = 1'b1;
                        w_start_byte = iData[15:8];
                    end else if (iData[7:0] != 8'h00) begin
                        w_start      = 1'b1;
                        w_start_byte = iData[7:0];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_POWER_WAIT;
            r_cnt        <= c_POWERON_LD;
            r_init_idx   <= 3'd0;
            r_init_done  <= 1'b0;
            r_byte       <= 8'h00;
            r_single     <= 1'b0;
            r_low        <= 1'b0;
            r_pend       <= 8'h00;
            r_pend_valid <= 1'b0;
            r_e          <= 1'b0;
            r_rs         <= 1'b0;
            r_data       <= 4'h0;
        end else begin
            case (r_state)
                c_POWER_WAIT: begin
                    if (r_cnt != '0)
                        r_cnt <= r_cnt - 1'b1;
                end
                c_NIB_SETUP: begin
                    if (r_cnt == '0) begin
                        r_e     <= 1'b1;
                        r_state <= c_NIB_HIGH;
                        r_cnt   <= c_EHIGH_LD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_NIB_HIGH: begin
                    if (r_cnt == '0) begin
                        r_e <= 1'b0;
                        if (!r_low && !r_single) begin
                            r_state <= c_NIB_GAP;
                            r_cnt   <= c_GAP_LD;
                        end else begin
                            r_state <= c_EXEC_WAIT;
                            r_cnt   <= w_exec_ld;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_NIB_GAP: begin
                    if (r_cnt == '0) begin
                        r_data  <= r_byte[3:0];
                        r_low   <= 1'b1;
                        r_state <= c_NIB_SETUP;
                        r_cnt   <= c_SETUP_LD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_EXEC_WAIT: begin
                    if (r_cnt == '0) begin
                        if (!r_init_done) begin
                            if (r_init_idx == 3'd7) begin
                                r_state     <= c_IDLE;
                                r_init_done <= 1'b1;
                            end else begin
                                r_init_idx <= w_next_idx;
                            end
                        end else begin
                            r_pend_valid <= 1'b0;
                            if (!r_pend_valid)
                                r_state <= c_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_IDLE: begin
                    if (iValid) begin
                        r_pend       <= iData[7:0];
                        r_pend_valid <= !iCommand && (iData[15:8] != 8'h00) && (iData[7:0] != 8'h00);
                        // An all-zero character word still costs one busy cycle
                        if (!w_start)
                            r_state <= c_SKIP;
                    end
                end
                c_SKIP: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_POWER_WAIT;
                    r_cnt   <= c_POWERON_LD;
                end
            endcase

            if (w_start) begin
                r_state  <= c_NIB_SETUP;
                r_cnt    <= c_SETUP_LD;
                r_byte   <= w_start_byte;
                r_rs     <= w_start_rs;
                r_single <= w_start_single;
                r_data   <= w_start_byte[7:4];
                r_low    <= 1'b0;
            end
        end
    end

    assign oReady    = (r_state == c_IDLE);
    assign oInitDone = r_init_done;
    assign oLCD_E    = r_e;
    assign oLCD_RS   = r_rs;
    assign oLCD_RW   = 1'b0;
    assign oLCD_Data = r_data;

endmodule

`default_nettype wire

// File: tb/tb_lcd_write_controller.sv
// ============================================================================
// Module      : tb_lcd_write_controller
// Description : Directed self-checking bench for lcd_write_controller.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_lcd_write_controller;

    logic        clk;
    logic        rst_n;
    logic        iValid;
    logic        iCommand;
    logic [15:0] iData;
    logic        oReady;
    logic        oInitDone;
    logic        oLCD_E;
    logic        oLCD_RS;
    logic        oLCD_RW;
    logic [3:0]  oLCD_Data;

    lcd_write_controller #(
        .T_POWERON    (100),
        .T_SETUP      (2),
        .T_EHIGH      (3),
        .T_NIBBLE_GAP (4),
        .T_INIT1      (20),
        .T_INIT2      (8),
        .T_CMD        (10),
        .T_CLEAR      (30)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .iValid    (iValid),
        .iCommand  (iCommand),
        .iData     (iData),
        .oReady    (oReady),
        .oInitDone (oInitDone),
        .oLCD_E    (oLCD_E),
        .oLCD_RS   (oLCD_RS),
        .oLCD_RW   (oLCD_RW),
        .oLCD_Data (oLCD_Data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int err_cnt;
    int chk_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus monitor: samples mid-cycle; cyc 0 is the cycle in which reset is released
    logic [4:0] nib_q [$];
    int         wid_q [$];
    int         cyc = -1;
    int         rise_cyc = 0;
    int         first_rise = -1;
    int         last_fall = -1;
    int         init_cyc = -1;
    int         ready_cyc = -1;
    int         rw_err = 0;
    int         stable_err = 0;
    logic       prev_e = 1'b0;
    logic       prev_done = 1'b0;
    logic       prev_ready = 1'b0;
    logic [4:0] prev_bus = 5'h00;

    always @(negedge clk) begin
        if (!rst_n) begin
            cyc        = -1;
            prev_e     = 1'b0;
            prev_done  = 1'b0;
            prev_ready = 1'b0;
            first_rise = -1;
            init_cyc   = -1;
            ready_cyc  = -1;
        end else begin
            cyc++;
            if (oLCD_RW !== 1'b0) rw_err++;
            if (oLCD_E && !prev_e) begin
                rise_cyc = cyc;
                if (first_rise < 0) first_rise = cyc;
            end
            if (oLCD_E && prev_e && ({oLCD_RS, oLCD_Data} !== prev_bus)) stable_err++;
            if (!oLCD_E && prev_e) begin
                nib_q.push_back(prev_bus);
                wid_q.push_back(cyc - rise_cyc);
                last_fall = cyc;
            end
            if (oInitDone && !prev_done) init_cyc = cyc;
            if (oReady && !prev_ready && ready_cyc < 0) ready_cyc = cyc;
            prev_e     = oLCD_E;
            prev_bus   = {oLCD_RS, oLCD_Data};
            prev_done  = oInitDone;
            prev_ready = oReady;
        end
    end

    logic [4:0] init_exp [12];
    int         busy;

    task automatic wait_init();
        int guard;
        guard = 0;
        while (!oInitDone && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        #1;
        check("init_done_reached", {31'd0, oInitDone}, 32'd1);
    endtask

    task automatic check_init(input string tag);
        check({tag, "_first_rise"}, first_rise, 32'd102);
        check({tag, "_done_cycle"}, init_cyc, 32'd284);
        check({tag, "_ready_with_done"}, ready_cyc, 32'd284);
        check({tag, "_clear_wait"}, init_cyc - last_fall, 32'd30);
        check({tag, "_nib_count"}, nib_q.size(), 32'd12);
        for (int i = 0; i < 12 && i < nib_q.size(); i++) begin
            check({tag, "_nib"}, {27'd0, nib_q[i]}, {27'd0, init_exp[i]});
            check({tag, "_e_width"}, wid_q[i], 32'd3);
        end
    endtask

    task automatic check_nibs(input string tag, input int n, input logic [19:0] exp);
        check({tag, "_nib_count"}, nib_q.size(), n);
        for (int i = 0; i < n && i < nib_q.size(); i++) begin
            check({tag, "_nib"}, {27'd0, nib_q[i]}, {27'd0, exp[19-5*i -: 5]});
            check({tag, "_e_width"}, wid_q[i], 32'd3);
        end
    endtask

    task automatic run_txn(input logic cmd, input logic [15:0] d, input bit poke, output int b);
        int guard;
        nib_q.delete();
        wid_q.delete();
        @(posedge clk); #2;
        iValid   = 1'b1;
        iCommand = cmd;
        iData    = d;
        @(posedge clk); #2;
        iValid   = 1'b0;
        iCommand = ~cmd;
        iData    = 16'hFFFF;
        b        = 0;
        guard    = 0;
        while (guard < 2000) begin
            @(negedge clk);
            if (oReady) break;
            b++;
            guard++;
            if (poke && b == 5) begin
                #1;
                iValid   = 1'b1;
                iCommand = 1'b0;
                iData    = 16'h5A5A;
                @(posedge clk); #2;
                iValid   = 1'b0;
            end
        end
        repeat (6) @(negedge clk);
        #1;
        iCommand = 1'b0;
        iData    = 16'h0000;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        init_exp = '{5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08,
                     5'h00, 5'h06, 5'h00, 5'h0C, 5'h00, 5'h01};
        err_cnt  = 0;
        chk_cnt  = 0;
        rst_n    = 1'b1;
        iValid   = 1'b0;
        iCommand = 1'b0;
        iData    = 16'h0000;
        #3 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_outputs", {26'd0, oLCD_E, oLCD_RS, oLCD_Data, oReady, oInitDone},
              32'd0);
        check("reset_rw", {31'd0, oLCD_RW}, 32'd0);

        rst_n = 1'b1;
        nib_q.delete();
        wid_q.delete();
        repeat (20) @(negedge clk);
        #1;
        check("ready_low_in_power_wait", {31'd0, oReady}, 32'd0);
        wait_init();
        check_init("init");

        run_txn(1'b0, 16'h4142, 1'b0, busy);
        check("word4142_busy", busy, 32'd48);
        check_nibs("word4142", 4, {5'h14, 5'h11, 5'h14, 5'h12});

        run_txn(1'b1, 16'h0001, 1'b0, busy);
        check("cmd01_busy", busy, 32'd44);
        check_nibs("cmd01", 2, {5'h00, 5'h01, 10'd0});

        run_txn(1'b0, 16'h0041, 1'b0, busy);
        check("word0041_busy", busy, 32'd24);
        check_nibs("word0041", 2, {5'h14, 5'h11, 10'd0});

        run_txn(1'b0, 16'h0000, 1'b0, busy);
        check("word0000_busy", busy, 32'd1);
        check_nibs("word0000", 0, 20'd0);

        run_txn(1'b0, 16'h4344, 1'b1, busy);
        check("poke_busy", busy, 32'd48);
        check_nibs("poke", 4, {5'h14, 5'h13, 5'h14, 5'h14});
        check("poke_ready_after", {31'd0, oReady}, 32'd1);

        // Async reset while E is high during the second nibble
        nib_q.delete();
        wid_q.delete();
        @(posedge clk); #2;
        iValid   = 1'b1;
        iCommand = 1'b0;
        iData    = 16'h4142;
        @(posedge clk); #2;
        iValid   = 1'b0;
        guard    = 0;
        while (guard < 200) begin
            @(negedge clk);
            #1;
            if (nib_q.size() == 1 && oLCD_E) break;
            guard++;
        end
        check("midreset_reached_e_high", {31'd0, oLCD_E}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", {26'd0, oLCD_E, oLCD_RS, oLCD_Data, oReady, oInitDone},
              32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        nib_q.delete();
        wid_q.delete();
        wait_init();
        check_init("reinit");

        check("rw_always_low", rw_err, 32'd0);
        check("bus_stable_while_e", stable_err, 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lcd_write_controller.md
Name: lcd_write_controller

Overview:
Executes the LCD instruction on the character LCD (HD44780-compatible, 4-bit bus, write-only). After reset it runs the power-on initialisation sequence autonomously. It then accepts 16-bit words holding two ASCII characters, or single command bytes, over a valid/ready handshake. Each byte is serialised as two nibbles with the required setup, enable-pulse and execution delays, and oReady gates further LCD instructions.

Parameters:
T_POWERON, 750000, cycles waited after reset before the first init nibble (15 ms at 50 MHz)
T_SETUP, 2, cycles with data/RS stable and E low before E rises
T_EHIGH, 12, cycles E held high per nibble
T_NIBBLE_GAP, 50, cycles with E low between the high and low nibble of a byte
T_INIT1, 205000, wait after the first init nibble 0x3
T_INIT2, 5000, wait after the second init nibble 0x3
T_CMD, 2000, execution wait after a normal byte, and after init nibbles 3 and 4
T_CLEAR, 82000, execution wait after command byte 0x01 or 0x02

Ports:
Clock  in  1  system clock; all state on rising edge
Reset  in  1  asynchronous, active-low reset
iValid  in  1  request present
iCommand  in  1  1 = iData[7:0] is one command byte (RS=0); 0 = iData is two characters (RS=1)
iData  in  16  characters: [15:8] sent first, then [7:0]; command: [7:0] only
oReady  out  1  high when idle and init complete; transfer occurs on iValid & oReady
oInitDone  out  1  high once the init sequence has finished; stays high until reset
oLCD_E  out  1  LCD enable
oLCD_RS  out  1  register select
oLCD_RW  out  1  constant 0
oLCD_Data  out  4  nibble bus (DB7..DB4)

Behaviour:
- Reset asserted, at any time including mid-transfer: all outputs 0 immediately, state to POWER_WAIT, captured data discarded. On release, the full init sequence reruns.
- Nibble pulse: data/RS driven; T_SETUP cycles E=0; T_EHIGH cycles E=1; E falls. Data and RS are held until the next nibble is driven.
- Byte: high-nibble pulse, T_NIBBLE_GAP, low-nibble pulse, then execution wait. The wait is T_CLEAR if RS=0 and byte is 0x01 or 0x02, otherwise T_CMD.
- States: POWER_WAIT (T_POWERON) -> INIT_NIB (RS=0):
  - single-nibble pulses 0x3 / wait T_INIT1, 0x3 / T_INIT2, 0x3 / T_CMD, 0x2 / T_CMD
  - INIT_BYTE: bytes 0x28, 0x06, 0x0C, 0x01
  - IDLE: oInitDone=1 set on IDLE entry, oReady=1
- IDLE, iValid=1 on an edge: iData, iCommand captured; oReady=0 from the next cycle; go to SEND.
  - iCommand=1: send iData[7:0] with RS=0.
  - iCommand=0: send iData[15:8], then iData[7:0], with RS=1.
  - A character byte equal to 0x00 is skipped, with no pulse and no wait. Word 0x0000 returns to IDLE in 1 cycle.
  - After the last byte's wait, return to IDLE.
- oReady=1 exactly when state=IDLE; it is a function of state only, not of iValid.
- iValid while oReady=0 is ignored; there is no queue. Input changes after capture have no effect.
- One wait counter, wide enough for max(T_POWERON, T_INIT1, T_CLEAR). It loads N-1 and the phase ends when it reaches 0, so each phase lasts exactly N cycles.
- Normal two-character word busy time = 2*(2*T_SETUP + 2*T_EHIGH + T_NIBBLE_GAP + T_CMD) cycles. It counts from the first cycle after acceptance to oReady re-high, exclusive.
- oLCD_E is registered and glitch-free. oLCD_Data and oLCD_RS never change while E=1.

Test Plan:
- Test parameters for all scenarios: T_POWERON=100, T_SETUP=2, T_EHIGH=3, T_NIBBLE_GAP=4, T_INIT1=20, T_INIT2=8, T_CMD=10, T_CLEAR=30.
- Reset release, monitor E falling edges -> latched nibbles 3,3,3,2,2,8,0,6,0,C,0,1 with RS=0. First E rise at cycle 102 after release. oInitDone and oReady rise together after the 0x01 clear wait of 30 cycles; RW=0 throughout.
- After init, iData=0x4142, iCommand=0 held 1 cycle -> nibbles 4,1,4,2 with RS=1; each E high exactly 3 cycles; gaps 4 cycles. oReady low for exactly 48 cycles, then high.
- iCommand=1, iData=0x0001 -> nibbles 0,1 with RS=0; post wait 30 cycles; busy time 2+3+4+2+3+30=44 cycles.
- iData=0x0041 (character) -> only nibbles 4,1 sent, busy 24 cycles. iData=0x0000 -> no E pulse, oReady low 1 cycle.
- Reset during second nibble with E=1 -> E, Data, RS, oReady, oInitDone go 0 asynchronously. After release, 100-cycle wait, then the init sequence restarts from 0x3.
- iValid pulsed with iData=0x5A5A while busy -> no extra nibbles. The current transfer completes unchanged.
